// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU.
// Optional feature macro used by this slice: ALU_OVF_EN (signed overflow output).
package alu_pkg;

    // Operating mode selected by the m input
    typedef enum logic {
        ARITH = 1'b0,
        LOGIC = 1'b1
    } alu_mode_e;

    // Function select names, taken from the logic-mode meaning of s
    typedef enum logic [3:0] {
        OP_NOT_A    = 4'h0,
        OP_NOR      = 4'h1,
        OP_NA_AND_B = 4'h2,
        OP_ZERO     = 4'h3,
        OP_NAND     = 4'h4,
        OP_NOT_B    = 4'h5,
        OP_XOR      = 4'h6,
        OP_A_AND_NB = 4'h7,
        OP_NA_OR_B  = 4'h8,
        OP_XNOR     = 4'h9,
        OP_B        = 4'hA,
        OP_AND      = 4'hB,
        OP_ONES     = 4'hC,
        OP_A_OR_NB  = 4'hD,
        OP_OR       = 4'hE,
        OP_A        = 4'hF
    } alu_op_e;

    // Cycles from an accepted input beat to its registered result
    localparam int ALU_LAT = 2;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: 16 logic and 16 arithmetic functions plus carry, equality
// and zero flags. Define ALU_OVF_EN to add the signed overflow output ovf.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       s,
    input  logic             m,
`ifdef ALU_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             aeb,
    output logic             zero
);

    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] logic_f;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   sum;

    assign ones = '1;

    // Logic-mode result and arithmetic operand selection, both keyed on s
    always_comb begin
        logic_f = '0;
        p       = '0;
        q       = '0;
        case (alu_op_e'(s))
            OP_NOT_A:    begin logic_f = ~a;        p = a;      q = '0;     end
            OP_NOR:      begin logic_f = ~(a | b);  p = a | b;  q = '0;     end
            OP_NA_AND_B: begin logic_f = ~a & b;    p = ~a | b; q = '0;     end
            OP_ZERO:     begin logic_f = '0;        p = ones;   q = '0;     end
            OP_NAND:     begin logic_f = ~(a & b);  p = a;      q = a & ~b; end
            OP_NOT_B:    begin logic_f = ~b;        p = a | b;  q = a & ~b; end
            OP_XOR:      begin logic_f = a ^ b;     p = a;      q = ~b;     end
            OP_A_AND_NB: begin logic_f = a & ~b;    p = a & ~b; q = ones;   end
            OP_NA_OR_B:  begin logic_f = ~a | b;    p = a;      q = a & b;  end
            OP_XNOR:     begin logic_f = ~(a ^ b);  p = a;      q = b;      end
            OP_B:        begin logic_f = b;         p = a | ~b; q = a & b;  end
            OP_AND:      begin logic_f = a & b;     p = a & b;  q = ones;   end
            OP_ONES:     begin logic_f = ones;      p = a;      q = a;      end
            OP_A_OR_NB:  begin logic_f = a | ~b;    p = a | b;  q = a;      end
            OP_OR:       begin logic_f = a | b;     p = a | ~b; q = a;      end
            OP_A:        begin logic_f = a;         p = a;      q = ones;   end
            default:     begin logic_f = '0;        p = '0;     q = '0;     end
        endcase
    end

    // Carry input is active-low: cin=0 adds one
    assign sum = {1'b0, p} + {1'b0, q} + {{WIDTH{1'b0}}, ~cin};

    // Mode mux and flags; carry-out only has meaning in arithmetic mode
    always_comb begin
        if (alu_mode_e'(m) == LOGIC) begin
            f    = logic_f;
            cout = 1'b0;
        end else begin
            f    = sum[WIDTH-1:0];
            cout = sum[WIDTH];
        end
        aeb  = (a == b);
        zero = (f == '0);
    end

`ifdef ALU_OVF_EN
    // Signed overflow: like-signed operands producing a result of the other sign
    assign ovf = (alu_mode_e'(m) == ARITH) &&
                 (p[WIDTH-1] == q[WIDTH-1]) &&
                 (sum[WIDTH-1] != p[WIDTH-1]);
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides.
// S1 holds the operand beat, S2 holds the computed result and flags.
// Define ALU_OVF_EN to add the registered signed overflow output ovf.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             aeb,
    output logic             zero,
`ifdef ALU_OVF_EN
    output logic             ovf,
`endif
    output logic [TAG_W-1:0] out_tag
);

    // Stage 1 state
    logic             s1_valid_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             cin_reg;
    logic [3:0]       s_reg;
    logic             m_reg;
    logic [TAG_W-1:0] tag_reg;

    // Stage 2 state
    logic             out_valid_reg;
    logic [WIDTH-1:0] f_reg;
    logic             cout_reg;
    logic             aeb_reg;
    logic             zero_reg;
    logic [TAG_W-1:0] out_tag_reg;

    // Combinational results of the beat sitting in S1
    logic [WIDTH-1:0] f_next;
    logic             cout_next;
    logic             aeb_next;
    logic             zero_next;

    logic             s2_load;

`ifdef ALU_OVF_EN
    logic             ovf_next;
    logic             ovf_reg;
`endif

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a    (a_reg),
        .b    (b_reg),
        .cin  (cin_reg),
        .s    (s_reg),
        .m    (m_reg),
`ifdef ALU_OVF_EN
        .ovf  (ovf_next),
`endif
        .f    (f_next),
        .cout (cout_next),
        .aeb  (aeb_next),
        .zero (zero_next)
    );

    // S2 frees up when empty or when its result is taken this edge;
    // S1 may refill in the same edge, so a full pipe still streams 1 beat/cycle
    assign s2_load  = !out_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || s2_load;

    // Stage 1: capture operands whenever the stage can accept
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            cin_reg      <= 1'b0;
            s_reg        <= '0;
            m_reg        <= 1'b0;
            tag_reg      <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                a_reg   <= in1;
                b_reg   <= in2;
                cin_reg <= cin;
                s_reg   <= s;
                m_reg   <= m;
                tag_reg <= in_tag;
            end
        end
    end

    // Stage 2: register result and flags together so they always describe one beat
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            f_reg         <= '0;
            cout_reg      <= 1'b0;
            aeb_reg       <= 1'b0;
            zero_reg      <= 1'b0;
            out_tag_reg   <= '0;
`ifdef ALU_OVF_EN
            ovf_reg       <= 1'b0;
`endif
        end else if (s2_load) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                f_reg       <= f_next;
                cout_reg    <= cout_next;
                aeb_reg     <= aeb_next;
                zero_reg    <= zero_next;
                out_tag_reg <= tag_reg;
`ifdef ALU_OVF_EN
                ovf_reg     <= ovf_next;
`endif
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = f_reg;
    assign cout      = cout_reg;
    assign aeb       = aeb_reg;
    assign zero      = zero_reg;
    assign out_tag   = out_tag_reg;
`ifdef ALU_OVF_EN
    assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard testbench for alu_pipe (WIDTH=8 main instance, WIDTH=16 spot check).
// Define ALU_OVF_EN to also exercise the overflow output.
`timescale 1ns/1ps
module tb_alu_pipe;

    localparam int W  = 8;
    localparam int TW = 4;

    // Per-bit truth tables of the logic functions, indexed by {a_bit, b_bit}
    localparam logic [3:0] LOGIC_TT [0:15] = '{
        4'b0011, 4'b0001, 4'b0010, 4'b0000,
        4'b0111, 4'b0101, 4'b0110, 4'b0100,
        4'b1011, 4'b1001, 4'b1010, 4'b1000,
        4'b1111, 4'b1101, 4'b1110, 4'b1100
    };

    typedef struct packed {
        logic [W-1:0]  f;
        logic          cout;
        logic          aeb;
        logic          zero;
        logic          ovf;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic          cin;
    logic [3:0]    s;
    logic          m;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic          cout;
    logic          aeb;
    logic          zero;
    logic [TW-1:0] out_tag;
`ifdef ALU_OVF_EN
    logic          ovf;
    logic          ovf16;
`endif

    // Second instance at WIDTH=16
    logic          in_valid16;
    logic          in_ready16;
    logic [15:0]   in1_16;
    logic [15:0]   in2_16;
    logic          out_valid16;
    logic [15:0]   out16;
    logic          cout16;
    logic          aeb16;
    logic          zero16;
    logic [TW-1:0] out_tag16;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .s         (s),
        .m         (m),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout),
        .aeb       (aeb),
        .zero      (zero),
`ifdef ALU_OVF_EN
        .ovf       (ovf),
`endif
        .out_tag   (out_tag)
    );

    alu_pipe #(.WIDTH(16), .TAG_W(TW)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in1       (in1_16),
        .in2       (in2_16),
        .cin       (1'b1),
        .s         (4'h9),
        .m         (1'b0),
        .in_tag    (4'h7),
        .out_valid (out_valid16),
        .out_ready (1'b1),
        .out       (out16),
        .cout      (cout16),
        .aeb       (aeb16),
        .zero      (zero16),
`ifdef ALU_OVF_EN
        .ovf       (ovf16),
`endif
        .out_tag   (out_tag16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model written from the function tables
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic [3:0] sel,
                                   input logic md, input logic [TW-1:0] tg);
        exp_t e;
        logic [3:0]   tt;
        logic [W-1:0] p;
        logic [W-1:0] q;
        logic [W:0]   sum;
        logic [W-1:0] all1;
        all1 = '1;
        e = '0;
        e.tag = tg;
        if (md) begin
            tt = LOGIC_TT[sel];
            for (int i = 0; i < W; i++) e.f[i] = tt[{a[i], b[i]}];
        end else begin
            case (sel)
                4'h0: begin p = a;      q = '0;     end
                4'h1: begin p = a | b;  q = '0;     end
                4'h2: begin p = ~a | b; q = '0;     end
                4'h3: begin p = all1;   q = '0;     end
                4'h4: begin p = a;      q = a & ~b; end
                4'h5: begin p = a | b;  q = a & ~b; end
                4'h6: begin p = a;      q = ~b;     end
                4'h7: begin p = a & ~b; q = all1;   end
                4'h8: begin p = a;      q = a & b;  end
                4'h9: begin p = a;      q = b;      end
                4'hA: begin p = a | ~b; q = a & b;  end
                4'hB: begin p = a & b;  q = all1;   end
                4'hC: begin p = a;      q = a;      end
                4'hD: begin p = a | b;  q = a;      end
                4'hE: begin p = a | ~b; q = a;      end
                default: begin p = a;   q = all1;   end
            endcase
            sum    = {1'b0, p} + {1'b0, q} + (c ? 9'd0 : 9'd1);
            e.f    = sum[W-1:0];
            e.cout = sum[W];
            e.ovf  = (p[W-1] == q[W-1]) && (sum[W-1] != p[W-1]);
        end
        e.aeb  = (a == b);
        e.zero = (e.f == '0);
        return e;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready)
                sb_q.push_back(model(in1, in2, cin, s, m, in_tag));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    $display("beat tag=%0h F=%02h cout=%0b aeb=%0b zero=%0b", out_tag, out, cout, aeb, zero);
                    check("F",    {24'd0, out},     {24'd0, e.f});
                    check("cout", {31'd0, cout},    {31'd0, e.cout});
                    check("aeb",  {31'd0, aeb},     {31'd0, e.aeb});
                    check("zero", {31'd0, zero},    {31'd0, e.zero});
                    check("tag",  {28'd0, out_tag}, {28'd0, e.tag});
`ifdef ALU_OVF_EN
                    check("ovf",  {31'd0, ovf},     {31'd0, e.ovf});
`endif
                end
            end
        end
    end

    // Present a beat and hold it until accepted; called just after a rising edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [3:0] sel, input logic md, input logic [TW-1:0] tg,
                        input bit release_stall);
        int waited = 0;
        in1 = a; in2 = b; cin = c; s = sel; m = md; in_tag = tg;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
            if (release_stall && waited >= 2) out_ready = 1'b1;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", {31'd0, (sb_q.size() == 0)}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out"},       {24'd0, out},       32'd0);
        check({tag, "_cout"},      {31'd0, cout},      32'd0);
        check({tag, "_aeb"},       {31'd0, aeb},       32'd0);
        check({tag, "_zero"},      {31'd0, zero},      32'd0);
        check({tag, "_out_tag"},   {28'd0, out_tag},   32'd0);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        @(posedge clk); #1;
    endtask

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t held;
        int   t0;
        int   n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in1 = '0; in2 = '0; cin = 1'b1; s = '0; m = 1'b0; in_tag = '0;
        in_valid16 = 1'b0; in1_16 = '0; in2_16 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");

        // Plain add, then A-B with equal operands
        send(8'hF0, 8'h20, 1'b1, 4'h9, 1'b0, 4'h1, 1'b0);
        send(8'h5A, 8'h5A, 1'b0, 4'h6, 1'b0, 4'h2, 1'b0);
        send(8'h80, 8'h01, 1'b0, 4'h6, 1'b0, 4'h3, 1'b0);
        idle();
        wait_drain();

        // Logic sweep
        for (int i = 0; i < 16; i++)
            send(8'hCC, 8'hAA, 1'b0, i[3:0], 1'b1, i[3:0], 1'b0);
        idle();
        wait_drain();

        // Back-to-back 16 beats: in_ready must never drop
        t0 = cyc;
        for (int i = 0; i < 16; i++)
            send(W'($urandom), W'($urandom), 1'($urandom), i[3:0], 1'b0, i[3:0], 1'b0);
        check("throughput_cycles", cyc - t0, 32'd16);
        idle();
        wait_drain();

        // Random ops with random backpressure
        for (int i = 0; i < 24; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            send(W'($urandom), W'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), i[3:0], 1'b1);
        end
        idle();
        out_ready = 1'b1;
        wait_drain();

        // Stall: two beats held in the pipe, third waits
        out_ready = 1'b0;
        held = model(8'h33, 8'h11, 1'b1, 4'h9, 1'b0, 4'hA);
        send(8'h33, 8'h11, 1'b1, 4'h9, 1'b0, 4'hA, 1'b0);
        send(8'h0F, 8'hF0, 1'b1, 4'hE, 1'b1, 4'hB, 1'b0);
        in1 = 8'h44; in2 = 8'h44; cin = 1'b0; s = 4'h6; m = 1'b0; in_tag = 4'hC;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready",  {31'd0, in_ready},  32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_out",       {24'd0, out},       {24'd0, held.f});
            check("stall_tag",       {28'd0, out_tag},   {28'd0, held.tag});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_release", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        idle();
        wait_drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b1, 4'h9, 1'b0, 4'h5, 1'b0);
        send(8'h56, 8'h78, 1'b1, 4'h9, 1'b0, 4'h6, 1'b0);
        idle();
        @(negedge clk);
        check("full_in_ready",  {31'd0, in_ready},  32'd0);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        check_reset_state("midrst");

        // WIDTH=16 spot check: 0x00F0 + 0x0020
        in1_16 = 16'h00F0; in2_16 = 16'h0020; in_valid16 = 1'b1;
        @(negedge clk);
        check("w16_in_ready", {31'd0, in_ready16}, 32'd1);
        @(posedge clk); #1 in_valid16 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid16 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("w16_valid", {31'd0, out_valid16}, 32'd1);
        check("w16_F",     {16'd0, out16},       32'h0110);
        check("w16_cout",  {31'd0, cout16},      32'd0);
        check("w16_zero",  {31'd0, zero16},      32'd0);
        check("w16_tag",   {28'd0, out_tag16},   32'd7);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
